pe_order_scheduler: RTL
=======================

// Module: pe_order_scheduler
// PURPOSE
//  Arbitrates order requests from NUM_PE processing engines onto the single shared payload generator.
//  Captures PE_enable requests and grants them one at a time, round-robin.
//  Assigns each granted frame its MsgSeqNum, watches the AXI-Stream output for frame end and returns a per-PE ack.
//  Sits between the PE array and the payload generator core.
// PARAMETERS
//  NUM_PE          10    number of requesting engines (2..32)
//  SEL_W           $clog2(NUM_PE)  width of gen_sel
//  TIMEOUT_CYCLES  64    stall watchdog limit; used only with PE_SCHED_TIMEOUT_EN
// PORTS
//  clk              in   1       system clock
//  reset            in   1       synchronous, active-high reset
//  PE_enable        in   NUM_PE  per-PE request; each cycle it is high counts as a request
//  seq_load         in   1       load seq_init into the sequence counter
//  seq_init         in   32      MsgSeqNum load value
//  tvalid/tready/tlast in 1 each generator output stream, monitored only
//  gen_start        out  1       one-cycle pulse: generator begins a frame for gen_sel
//  gen_sel          out  SEL_W   index of the granted PE; held until the frame ends
//  MsgSeqNum        out  32      sequence number of the current frame; held until the frame ends
//  PE_acks          out  NUM_PE  one-hot, one-cycle pulse when the PE's frame is complete
//  pending          out  NUM_PE  captured, not-yet-granted requests
//  busy             out  1       a frame is in flight
//  timeout_err      out  1       one-cycle pulse when a frame is aborted by the watchdog (0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0; rr_ptr=0; seq=0; state IDLE.
//    Reset mid-frame drops the frame with no ack and clears pending.
//  Capture: pending[i] <= 1 when PE_enable[i]=1.
//    Multiple requests coalesce; there is no count.
//    A request from the in-service PE is queued as a new pending request.
//    A request arriving on the cycle of that PE's own ack is also kept.
//  FSM IDLE: when pending!=0, the rr_arbiter picks the first set bit at or after rr_ptr (wraps).
//    Registered outputs: gen_sel=winner, gen_start=1, MsgSeqNum=seq, busy=1; clear pending[winner]; -> STREAM.
//  FSM STREAM: on tvalid&tready&tlast, PE_acks[gen_sel]=1 for one cycle, seq<=seq+1 (32-bit wrap), rr_ptr<=gen_sel+1 (wraps at NUM_PE), busy=0; -> IDLE.
//    Beats without tlast are ignored.
//  Latency:
//    PE_enable high in cycle c -> pending visible in c+1 -> gen_start in c+2 (if idle).
//    tlast accepted in cycle t -> PE_acks in t+1 -> next gen_start at t+2 at the earliest.
//  seq_load has priority over the increment on the same cycle.
//    It does not alter the MsgSeqNum of a frame already in flight.
//  tvalid/tlast seen while IDLE are ignored. gen_start never overlaps an in-flight frame.
// CONFIGURATION
//  PE_SCHED_TIMEOUT_EN defined:
//    A stall counter counts STREAM cycles and clears on every tvalid&tready.
//    When it reaches TIMEOUT_CYCLES: timeout_err pulse, no PE_acks, seq not incremented, rr_ptr advances, -> IDLE.
//  Macro absent: no counter; timeout_err tied 0; STREAM waits indefinitely.
// STRUCTURE
//  pe_sched_pkg: state enum {IDLE,STREAM}, SEQ_W=32, function for the one-hot to index conversion.
//  Sub-module rr_arbiter #(N): combinational rotate-priority pick.
//    Inputs req and ptr; outputs grant_idx and any.
//  The top level holds the FSM, pending reg, seq counter and watchdog.
// TESTING
//  1. Reset, seq_load 0x0b23; PE_enable[1] pulse; 3-beat frame with tlast on beat 3.
//     -> gen_start 2 cycles after the request, gen_sel=1, MsgSeqNum=0x0b23, PE_acks=0x002 one cycle after tlast.
//  2. PE_enable[0] and [2] pulsed together, rr_ptr=2 (after scenario 1).
//     -> PE2 granted first (seq 0x0b24), then PE0 (seq 0x0b25).
//     -> pending=0x005 and then 0x001 during the sequence.
//  3. All 10 PEs held high for 25 frames -> grant order 0..9 wraps with no PE granted twice before another.
//     -> seq increments by 1 per frame.
//  4. PE_enable[3] re-pulsed during its own frame and on its ack cycle.
//     -> exactly one extra grant to PE3; 3 pulses while pending coalesce to 1.
//  5. tready held low with tvalid=1 for 100 cycles.
//     -> with the macro: timeout_err at cycle 64 of the stall, no ack, seq unchanged.
//     -> without the macro: busy stays 1, then completes normally once tready rises.
//  6. reset asserted mid-frame -> next cycle all outputs 0, pending=0, no PE_acks.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// Shared types and helpers for the PE order scheduler: FSM state encoding,
// sequence-number width and the one-hot to index conversion used by the arbiter.
package pe_sched_pkg;

  localparam int SEQ_W  = 32;
  localparam int MAX_PE = 32;
  localparam int IDX_W  = 5;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Collapses a one-hot vector into its bit position; zero input gives index 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_PE-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PE; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pe_order_scheduler_rr_arbiter.sv
// Combinational rotate-priority arbiter: picks the first set request at or
// after ptr, wrapping back to bit 0 when nothing at or above ptr is requesting.
module rr_arbiter
  import pe_sched_pkg::*;
#(
  parameter int N     = 10,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;
  logic [N-1:0] pick;
  logic [N-1:0] grant;

  // Requests at or above ptr take priority; otherwise fall back to the lowest
  // request overall, which is the wrap-around case.
  assign upper_mask = {N{1'b1}} << ptr;
  assign upper_req  = req & upper_mask;
  assign pick       = (upper_req != '0) ? upper_req : req;
  assign grant      = pick & (~pick + N'(1));

  assign any       = (req != '0);
  assign grant_idx = SEL_W'(onehot_to_idx(MAX_PE'(grant)));

endmodule

// File: rtl/pe_order_scheduler.sv
// Round-robin scheduler granting PE order requests onto one payload generator.
// Optional stall watchdog enabled by defining PE_SCHED_TIMEOUT_EN.
module pe_order_scheduler
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE         = 10,
  parameter int SEL_W          = $clog2(NUM_PE),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PE-1:0] PE_enable,
  input  logic              seq_load,
  input  logic [SEQ_W-1:0]  seq_init,
  input  logic              tvalid,
  input  logic              tready,
  input  logic              tlast,
  output logic              gen_start,
  output logic [SEL_W-1:0]  gen_sel,
  output logic [SEQ_W-1:0]  MsgSeqNum,
  output logic [NUM_PE-1:0] PE_acks,
  output logic [NUM_PE-1:0] pending,
  output logic              busy,
  output logic              timeout_err
);

  state_t            state;
  state_t            state_nxt;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEQ_W-1:0]  seq;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_any;
  logic              beat;
  logic              last_beat;
  logic              start_frame;
  logic              end_frame;
  logic              abort_frame;
  logic              stall_expired;
  logic [NUM_PE-1:0] grant_mask;
  logic [NUM_PE-1:0] ack_mask;
  logic [SEL_W-1:0]  next_ptr;

  rr_arbiter #(
    .N     (NUM_PE),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign beat       = tvalid & tready;
  assign last_beat  = beat & tlast;
  assign grant_mask = NUM_PE'(1) << arb_idx;
  assign ack_mask   = NUM_PE'(1) << gen_sel;
  assign next_ptr   = (gen_sel == SEL_W'(NUM_PE - 1)) ? '0 : gen_sel + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    abort_frame = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          start_frame = 1'b1;
          state_nxt   = STREAM;
        end
      end
      STREAM: begin
        if (last_beat) begin
          end_frame = 1'b1;
          state_nxt = IDLE;
        end else if (stall_expired) begin
          abort_frame = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // New requests are OR-ed in after the grant clears its bit, so a PE that
  // re-requests on the very cycle it wins still keeps a pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      gen_start <= 1'b0;
      gen_sel   <= '0;
      MsgSeqNum <= '0;
      PE_acks   <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      seq       <= '0;
    end else begin
      pending   <= (pending & ~(start_frame ? grant_mask : '0)) | PE_enable;
      gen_start <= start_frame;
      PE_acks   <= end_frame ? ack_mask : '0;
      if (start_frame) begin
        gen_sel   <= arb_idx;
        MsgSeqNum <= seq;
        busy      <= 1'b1;
      end
      if (end_frame || abort_frame) begin
        busy   <= 1'b0;
        rr_ptr <= next_ptr;
      end
      if (seq_load) begin
        seq <= seq_init;
      end else if (end_frame) begin
        seq <= seq + SEQ_W'(1);
      end
    end
  end

`ifdef PE_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;

  // Counts consecutive streaming cycles without a handshake; any accepted beat restarts it.
  always_ff @(posedge clk) begin
    if (reset || (state != STREAM) || beat) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign stall_expired = (state == STREAM) && !beat &&
                         (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort_frame;
    end
  end
`else
  assign stall_expired = 1'b0;
  // Constant 0: the limit only has meaning when the watchdog is built in.
  assign timeout_err   = (TIMEOUT_CYCLES < 0);
`endif

endmodule
